tlb_maint_ctrl: RTL and testbench
=================================

// Module: tlb_maint_ctrl
// PURPOSE
//  Owns the TLB write port. It runs INVTLB as a multi-cycle walk over every TLB entry.
//  Each cycle it reads one entry, matches it against the INVTLB op and clears its E bit.
//  It also arbitrates the write port between this walk and WB-stage TLBWR/TLBFILL.
//  It holds the TLBFILL round-robin index. Sits between wb_stage and the TLB array.
//  busy feeds ws_ready_go, so WB holds the INVTLB and any new TLB write until done.
// PARAMETERS
//  TLBNUM   16  number of TLB entries; must be a power of two
//  IDX_W     4  log2(TLBNUM)
//  ENTRY_W  89  packed entry width, layout below
// PORTS
//  clk          in   1        core clock
//  resetn       in   1        asynchronous, active-low reset
//  inv_req      in   1        INVTLB valid at WB; held high until inv_ack
//  inv_op       in   5        INVTLB op field
//  inv_asid     in   10       rj[9:0]
//  inv_va       in   32       rk; VPPN = inv_va[31:13]
//  inv_ack      out  1        one-cycle pulse: walk complete (or op illegal)
//  inv_illegal  out  1        valid with inv_ack; op>6, no entry modified
//  busy         out  1        walk in progress (states WALK, DONE)
//  ws_we        in   1        WB TLBWR/TLBFILL write request
//  ws_fill      in   1        with ws_we: TLBFILL, so index comes from fill_ptr
//  ws_w_index   in   IDX_W    TLBWR index (from CSR.TLBIDX)
//  ws_w_entry   in   ENTRY_W  entry to write
//  ws_w_grant   out  1        ws_we && !busy: WB write performed this cycle
//  we           out  1        TLB write enable
//  w_index      out  IDX_W    TLB write index
//  w_entry      out  ENTRY_W  TLB write data
//  r_index      out  IDX_W    TLB read index (walker owns it only while busy)
//  r_entry      in   ENTRY_W  TLB read data, combinational from r_index
// BEHAVIOUR
//  Entry layout (MSB->LSB):
//   {e, ps[5:0], vppn[18:0], asid[9:0], g,
//    ppn0[19:0], plv0, mat0, d0, v0, ppn1[19:0], plv1, mat1, d1, v1}
//  Reset (resetn low, async): state=IDLE, cnt=0, fill_ptr=0, latched op/asid/va=0.
//   Outputs are forced to 0: we, w_index, w_entry, r_index, busy, inv_ack, inv_illegal, ws_w_grant.
//  FSM IDLE -> WALK -> DONE -> IDLE.
//  - IDLE: r_index = ws_w_index. On inv_req, latch op, asid and va.
//    - op<=6: go to WALK with cnt=0.
//    - else: go to DONE and flag illegal.
//    A same-cycle ws_we is still granted in IDLE; the walk starts the next cycle.
//  - WALK: r_index=cnt. Per cycle, hit = r_entry.e && match(op, r_entry); then:
//      we=hit, w_index=cnt, w_entry=r_entry with e=0.
//    cnt++ each cycle. At cnt==TLBNUM-1, go to DONE (no wrap past the last entry).
//  - DONE: inv_ack=1 (and inv_illegal if flagged) for exactly one cycle, then IDLE.
//    inv_req is not re-sampled in DONE; WB drops it on ack.
//  Match by op:
//   - 0,1: all entries
//   - 2: g=1
//   - 3: g=0
//   - 4: g=0 && asid==inv_asid
//   - 5: g=0 && asid==inv_asid && va_hit
//   - 6: (g=1 || asid==inv_asid) && va_hit
//   va_hit: ps==21 compares vppn[18:9]; otherwise all 19 bits.
//  Latency: inv_req at cycle 0 -> writes on cycles 1..TLBNUM -> inv_ack at cycle TLBNUM+1.
//  Write-port mux (outside WALK):
//   - we = ws_w_grant.
//   - w_index = ws_fill ? fill_ptr : ws_w_index.
//   - w_entry = ws_w_entry.
//  fill_ptr increments only on a granted fill, wrapping TLBNUM-1 -> 0. Never touched by the walk.
//  ws_we while busy: no grant and no write; WB stays stalled through busy.
//  Reset mid-walk: walk abandoned, no ack. Entries already cleared stay cleared.
// STRUCTURE
//  mycpu.h gets: `TLBNUM, INVTLB op codes, and ENTRY_W plus per-field bit offsets
//  as macros shared with the tlb and wb_stage.
//  Sub-module tlb_inv_match (combinational: op, asid, va, entry -> hit) is instantiated once.
// TESTING
//  1. Reset, then 16 TLBWR, all e=1. INVTLB op=0 -> we on 16 consecutive cycles,
//     idx 0..15, all e=0; ack at cycle 17.
//  2. Entries 3,7 g=1, rest g=0. op=2 -> we only at idx 3,7; op=3 -> the other 14.
//  3. Entry 5 asid=0x12, vppn=0x1234, ps=12. op=5, asid=0x12, va=0x02468000
//     -> only idx5 cleared. Same with ps=21 and va low vppn bits differing -> still hits.
//  4. op=7 -> inv_ack + inv_illegal one cycle after req; we never asserted.
//  5. ws_we during walk -> ws_w_grant=0, no stray write. 17 granted TLBFILLs
//     -> w_index 0..15 then 0.
//  6. resetn low at walk cycle 8 -> busy=0 and we=0 immediately, no ack;
//     entries 0..7 cleared, entries 8..15 intact.

Source files
------------

// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared TLB geometry, entry field offsets, INVTLB op codes and walker state
// for the TLB maintenance controller.
package tlb_maint_ctrl_pkg;

    localparam int TLBNUM  = 16;
    localparam int IDX_W   = 4;
    localparam int ENTRY_W = 89;

    // Entry field positions, MSB first: {e, ps, vppn, asid, g, page0, page1}
    localparam int E_BIT     = 88;
    localparam int PS_LSB    = 82;
    localparam int VPPN_LSB  = 63;
    localparam int ASID_LSB  = 53;
    localparam int G_BIT     = 52;

    localparam logic [4:0] INV_ALL0        = 5'd0;
    localparam logic [4:0] INV_ALL1        = 5'd1;
    localparam logic [4:0] INV_GLOBAL      = 5'd2;
    localparam logic [4:0] INV_NONGLOBAL   = 5'd3;
    localparam logic [4:0] INV_ASID        = 5'd4;
    localparam logic [4:0] INV_ASID_VA     = 5'd5;
    localparam logic [4:0] INV_G_ASID_VA   = 5'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } walk_state_e;

    // A 4MB page (ps==21) only distinguishes the upper 10 VPPN bits.
    function automatic logic va_match(input logic [5:0] ps,
                                      input logic [18:0] vppn,
                                      input logic [18:0] va_vppn);
        if (ps == 6'd21) begin
            return vppn[18:9] == va_vppn[18:9];
        end
        return vppn == va_vppn;
    endfunction

endpackage

// File: rtl/tlb_maint_ctrl_match.sv
// Combinational INVTLB match of one TLB entry against the latched op, ASID and VA.
module tlb_inv_match
    import tlb_maint_ctrl_pkg::*;
(
    input  logic [4:0]         op,
    input  logic [9:0]         asid,
    input  logic [31:0]        va,
    input  logic [ENTRY_W-1:0] entry,
    output logic               hit
);

    logic        e;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic [9:0]  e_asid;
    logic        va_hit;
    logic        asid_hit;
    logic        op_match;
    logic        unused_bits;

    assign e        = entry[E_BIT];
    assign g        = entry[G_BIT];
    assign ps       = entry[PS_LSB +: 6];
    assign vppn     = entry[VPPN_LSB +: 19];
    assign e_asid   = entry[ASID_LSB +: 10];
    assign va_hit   = va_match(ps, vppn, va[31:13]);
    assign asid_hit = (e_asid == asid);

    // Page payloads and the in-page VA offset take no part in matching.
    assign unused_bits = ^{entry[G_BIT-1:0], va[12:0]};

    always_comb begin
        op_match = 1'b0;
        case (op)
            INV_ALL0, INV_ALL1: op_match = 1'b1;
            INV_GLOBAL:         op_match = g;
            INV_NONGLOBAL:      op_match = !g;
            INV_ASID:           op_match = !g && asid_hit;
            INV_ASID_VA:        op_match = !g && asid_hit && va_hit;
            INV_G_ASID_VA:      op_match = (g || asid_hit) && va_hit;
            default:            op_match = 1'b0;
        endcase
    end

    assign hit = e && op_match;

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB write-port owner: walks every entry for INVTLB and otherwise forwards
// WB-stage TLBWR/TLBFILL writes, keeping the TLBFILL round-robin pointer.
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               inv_req,
    input  logic [4:0]         inv_op,
    input  logic [9:0]         inv_asid,
    input  logic [31:0]        inv_va,
    output logic               inv_ack,
    output logic               inv_illegal,
    output logic               busy,
    input  logic               ws_we,
    input  logic               ws_fill,
    input  logic [IDX_W-1:0]   ws_w_index,
    input  logic [ENTRY_W-1:0] ws_w_entry,
    output logic               ws_w_grant,
    output logic               we,
    output logic [IDX_W-1:0]   w_index,
    output logic [ENTRY_W-1:0] w_entry,
    output logic [IDX_W-1:0]   r_index,
    input  logic [ENTRY_W-1:0] r_entry
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    walk_state_e      state_q,    state_d;
    logic [IDX_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [4:0]       op_q,       op_d;
    logic [9:0]       asid_q,     asid_d;
    logic [31:0]      va_q,       va_d;
    logic             illegal_q,  illegal_d;
    logic             walk_hit;
    logic             busy_w;
    logic             grant_w;

    tlb_inv_match u_match (
        .op    (op_q),
        .asid  (asid_q),
        .va    (va_q),
        .entry (r_entry),
        .hit   (walk_hit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fill_ptr_q <= '0;
            op_q       <= '0;
            asid_q     <= '0;
            va_q       <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_ptr_q <= fill_ptr_d;
            op_q       <= op_d;
            asid_q     <= asid_d;
            va_q       <= va_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_ptr_d  = fill_ptr_q;
        op_d        = op_q;
        asid_d      = asid_q;
        va_d        = va_q;
        illegal_d   = illegal_q;

        busy_w      = (state_q != ST_IDLE);
        grant_w     = ws_we && !busy_w;

        ws_w_grant  = grant_w;
        busy        = busy_w;
        inv_ack     = 1'b0;
        inv_illegal = 1'b0;
        we          = grant_w;
        w_index     = ws_fill ? fill_ptr_q : ws_w_index;
        w_entry     = ws_w_entry;
        r_index     = ws_w_index;

        if (grant_w && ws_fill) begin
            fill_ptr_d = fill_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (inv_req) begin
                    op_d   = inv_op;
                    asid_d = inv_asid;
                    va_d   = inv_va;
                    cnt_d  = '0;
                    if (inv_op <= INV_G_ASID_VA) begin
                        state_d   = ST_WALK;
                        illegal_d = 1'b0;
                    end else begin
                        state_d   = ST_DONE;
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_WALK: begin
                r_index          = cnt_q;
                we               = walk_hit;
                w_index          = cnt_q;
                w_entry          = r_entry;
                w_entry[E_BIT]   = 1'b0;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                inv_ack     = 1'b1;
                inv_illegal = illegal_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write-port outputs are combinational from WB inputs, so hold them quiet in reset.
        if (!resetn) begin
            ws_w_grant  = 1'b0;
            busy        = 1'b0;
            inv_ack     = 1'b0;
            inv_illegal = 1'b0;
            we          = 1'b0;
            w_index     = '0;
            w_entry     = '0;
            r_index     = '0;
        end
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Self-checking bench for tlb_maint_ctrl: a behavioural TLB image and INVTLB
// rule model predict every write-port cycle and the final TLB contents.
module tb_tlb_maint_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int EW = 89;

    logic          clk;
    logic          resetn;
    logic          inv_req;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [31:0]   inv_va;
    logic          inv_ack;
    logic          inv_illegal;
    logic          busy;
    logic          ws_we;
    logic          ws_fill;
    logic [IW-1:0] ws_w_index;
    logic [EW-1:0] ws_w_entry;
    logic          ws_w_grant;
    logic          we;
    logic [IW-1:0] w_index;
    logic [EW-1:0] w_entry;
    logic [IW-1:0] r_index;
    logic [EW-1:0] r_entry;

    int vec_cnt;
    int err_cnt;

    logic [EW-1:0] mem     [N];
    logic [EW-1:0] exp_mem [N];
    int            exp_fill;

    tlb_maint_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .inv_req     (inv_req),
        .inv_op      (inv_op),
        .inv_asid    (inv_asid),
        .inv_va      (inv_va),
        .inv_ack     (inv_ack),
        .inv_illegal (inv_illegal),
        .busy        (busy),
        .ws_we       (ws_we),
        .ws_fill     (ws_fill),
        .ws_w_index  (ws_w_index),
        .ws_w_entry  (ws_w_entry),
        .ws_w_grant  (ws_w_grant),
        .we          (we),
        .w_index     (w_index),
        .w_entry     (w_entry),
        .r_index     (r_index),
        .r_entry     (r_entry)
    );

    // Clock and the TLB array the controller writes into.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign r_entry = mem[r_index];
    always @(posedge clk) begin
        if (we) mem[w_index] <= w_entry;
    end

    function automatic logic [EW-1:0] mk(input bit e, input logic [5:0] ps,
                                         input logic [18:0] vppn,
                                         input logic [9:0] asid, input bit g);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {e, ps, vppn, asid, g, r[51:0]};
    endfunction

    // INVTLB rules written from the field definitions.
    function automatic bit ref_hit(input logic [4:0] op, input logic [9:0] asid,
                                   input logic [31:0] va, input logic [EW-1:0] ent);
        bit          valid;
        bit          glob;
        int          ps;
        int          sig_bits;
        logic [18:0] vppn;
        logic [18:0] va_vppn;
        logic [9:0]  easid;
        bit          va_hit;
        bit          asid_hit;
        valid    = ent[88];
        ps       = int'(ent[87:82]);
        vppn     = ent[81:63];
        easid    = ent[62:53];
        glob     = ent[52];
        va_vppn  = va[31:13];
        sig_bits = (ps == 21) ? 10 : 19;
        va_hit   = ((vppn >> (19 - sig_bits)) == (va_vppn >> (19 - sig_bits)));
        asid_hit = (easid == asid);
        if (!valid) return 1'b0;
        case (int'(op))
            0, 1:    return 1'b1;
            2:       return glob;
            3:       return !glob;
            4:       return !glob && asid_hit;
            5:       return !glob && asid_hit && va_hit;
            6:       return (glob || asid_hit) && va_hit;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tlb_write(input int idx, input logic [EW-1:0] ent, input bit fill);
        int exp_idx;
        @(negedge clk);
        ws_we      = 1'b1;
        ws_fill    = fill;
        ws_w_index = fill ? IW'($urandom_range(0, N - 1)) : IW'(idx);
        ws_w_entry = ent;
        exp_idx    = fill ? exp_fill : idx;
        #1;
        vec_cnt++;
        if ({ws_w_grant, we, w_index, w_entry} !== {1'b1, 1'b1, IW'(exp_idx), ent}) begin
            err_cnt++;
            $display("FAIL write_port: got grant=%b we=%b idx=%0d entry=%h, want grant=1 we=1 idx=%0d entry=%h",
                     ws_w_grant, we, w_index, w_entry, exp_idx, ent);
        end
        exp_mem[exp_idx] = ent;
        if (fill) exp_fill = (exp_fill + 1) % N;
        @(posedge clk);
        #1;
        ws_we   = 1'b0;
        ws_fill = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < N; i++) begin
            vec_cnt++;
            if (mem[i] !== exp_mem[i]) begin
                err_cnt++;
                $display("FAIL %s mem[%0d]: got %h want %h", name, i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic run_inv(input logic [4:0] op, input logic [9:0] asid,
                           input logic [31:0] va, input bit noise, input bit pre_wr,
                           input int pre_idx, input logic [EW-1:0] pre_ent,
                           input int abort_at);
        bit            hit [N];
        bit            legal;
        bit            aborted;
        logic [EW-1:0] cleared;
        legal   = (op <= 5'd6);
        aborted = 1'b0;
        @(negedge clk);
        inv_req    = 1'b1;
        inv_op     = op;
        inv_asid   = asid;
        inv_va     = va;
        ws_we      = pre_wr;
        ws_fill    = 1'b0;
        ws_w_index = IW'(pre_idx);
        ws_w_entry = pre_ent;
        #1;
        vec_cnt++;
        if ({busy, inv_ack, ws_w_grant, we} !== {1'b0, 1'b0, pre_wr, pre_wr}) begin
            err_cnt++;
            $display("FAIL inv_req_cycle: got busy=%b ack=%b grant=%b we=%b, want 0 0 %b %b",
                     busy, inv_ack, ws_w_grant, we, pre_wr, pre_wr);
        end
        if (pre_wr) begin
            vec_cnt++;
            if ({w_index, w_entry} !== {IW'(pre_idx), pre_ent}) begin
                err_cnt++;
                $display("FAIL same_cycle_write: got idx=%0d entry=%h want idx=%0d entry=%h",
                         w_index, w_entry, pre_idx, pre_ent);
            end
            exp_mem[pre_idx] = pre_ent;
        end
        for (int i = 0; i < N; i++) hit[i] = legal && ref_hit(op, asid, va, exp_mem[i]);

        if (!legal) begin
            @(negedge clk);
            ws_we = 1'b0;
            #1;
            vec_cnt++;
            if ({inv_ack, inv_illegal, busy, we} !== 4'b1110) begin
                err_cnt++;
                $display("FAIL illegal_ack: got ack=%b illegal=%b busy=%b we=%b, want 1 1 1 0",
                         inv_ack, inv_illegal, busy, we);
            end
            inv_req = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                @(negedge clk);
                if (k == abort_at) begin
                    resetn  = 1'b0;
                    inv_req = 1'b0;
                    ws_we   = 1'b1;
                    #1;
                    vec_cnt++;
                    if ({busy, we, inv_ack, inv_illegal, ws_w_grant} !== 5'b00000) begin
                        err_cnt++;
                        $display("FAIL reset_mid_walk: got busy=%b we=%b ack=%b illegal=%b grant=%b, want all 0",
                                 busy, we, inv_ack, inv_illegal, ws_w_grant);
                    end
                    ws_we    = 1'b0;
                    exp_fill = 0;
                    aborted  = 1'b1;
                    break;
                end
                if (noise) begin
                    ws_we      = 1'($urandom_range(0, 1));
                    ws_fill    = 1'($urandom_range(0, 1));
                    ws_w_index = IW'($urandom_range(0, N - 1));
                    ws_w_entry = mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), 1'b0);
                end else begin
                    ws_we = 1'b0;
                end
                #1;
                cleared     = exp_mem[k];
                cleared[88] = 1'b0;
                vec_cnt++;
                if ({busy, ws_w_grant, inv_ack, we, w_index, r_index, w_entry} !==
                    {1'b1, 1'b0, 1'b0, hit[k], IW'(k), IW'(k), cleared}) begin
                    err_cnt++;
                    $display("FAIL walk_cycle%0d: got busy=%b grant=%b ack=%b we=%b widx=%0d ridx=%0d entry=%h, want 1 0 0 %b %0d %0d %h",
                             k, busy, ws_w_grant, inv_ack, we, w_index, r_index, w_entry,
                             hit[k], k, k, cleared);
                end
                if (hit[k]) exp_mem[k] = cleared;
            end
            if (aborted) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (c == 1) resetn = 1'b1;
                    #1;
                    vec_cnt++;
                    if ({inv_ack, busy, we} !== 3'b000) begin
                        err_cnt++;
                        $display("FAIL post_reset_quiet%0d: got ack=%b busy=%b we=%b, want 0 0 0",
                                 c, inv_ack, busy, we);
                    end
                end
            end else begin
                @(negedge clk);
                ws_we = 1'b0;
                #1;
                vec_cnt++;
                if ({inv_ack, inv_illegal, busy, we} !== 4'b1010) begin
                    err_cnt++;
                    $display("FAIL walk_ack: got ack=%b illegal=%b busy=%b we=%b, want 1 0 1 0",
                             inv_ack, inv_illegal, busy, we);
                end
                inv_req = 1'b0;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            #1;
            vec_cnt++;
            if ({inv_ack, inv_illegal, busy} !== 3'b000) begin
                err_cnt++;
                $display("FAIL ack_one_cycle: got ack=%b illegal=%b busy=%b, want 0 0 0",
                         inv_ack, inv_illegal, busy);
            end
        end
        check_mem("after_inv");
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        ws_we      = 1'b1;
        ws_fill    = 1'b1;
        ws_w_index = 4'd9;
        ws_w_entry = mk(1'b1, 6'd12, 19'h1, 10'h1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++;
        if ({we, w_index, w_entry, r_index, busy, inv_ack, inv_illegal, ws_w_grant} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got we=%b widx=%0d entry=%h ridx=%0d busy=%b ack=%b ill=%b grant=%b, want all 0",
                     we, w_index, w_entry, r_index, busy, inv_ack, inv_illegal, ws_w_grant);
        end
        ws_we   = 1'b0;
        ws_fill = 1'b0;
        @(negedge clk);
        resetn   = 1'b1;
        exp_fill = 0;
    endtask

    task automatic test_invtlb_all();
        for (int i = 0; i < N; i++)
            tlb_write(i, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), 1'($urandom)), 1'b0);
        run_inv(5'd0, 10'd0, 32'd0, 1'b0, 1'b0, 0, '0, -1);
    endtask

    task automatic test_global();
        for (int i = 0; i < N; i++)
            tlb_write(i, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), (i == 3 || i == 7)), 1'b0);
        run_inv(5'd2, 10'($urandom), $urandom, 1'b0, 1'b0, 0, '0, -1);
        for (int i = 0; i < N; i++)
            if (i == 3 || i == 7) tlb_write(i, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), 1'b1), 1'b0);
        run_inv(5'd3, 10'($urandom), $urandom, 1'b0, 1'b0, 0, '0, -1);
    endtask

    task automatic test_va_match();
        for (int i = 0; i < N; i++) begin
            if (i == 5) tlb_write(i, mk(1'b1, 6'd12, 19'h01234, 10'h012, 1'b0), 1'b0);
            else        tlb_write(i, mk(1'b1, 6'd12, 19'h70000 | 19'(i), 10'h012, 1'b0), 1'b0);
        end
        run_inv(5'd5, 10'h012, 32'h0246_8000, 1'b0, 1'b0, 0, '0, -1);
        tlb_write(5, mk(1'b1, 6'd21, 19'h01234, 10'h012, 1'b0), 1'b0);
        run_inv(5'd5, 10'h012, {10'h009, 9'h1C3, 13'h00AB}, 1'b0, 1'b0, 0, '0, -1);
        tlb_write(9, mk(1'b1, 6'd12, 19'h01234, 10'h3FF, 1'b1), 1'b0);
        tlb_write(5, mk(1'b1, 6'd12, 19'h01234, 10'h055, 1'b0), 1'b0);
        run_inv(5'd6, 10'h055, 32'h0246_8123, 1'b0, 1'b0, 0, '0, -1);
    endtask

    task automatic test_illegal();
        for (int i = 0; i < N; i++)
            tlb_write(i, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), 1'($urandom)), 1'b0);
        run_inv(5'd7, 10'd0, 32'd0, 1'b0, 1'b0, 0, '0, -1);
        run_inv(5'($urandom_range(8, 31)), 10'($urandom), $urandom, 1'b0, 1'b0, 0, '0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++)
            tlb_write(i, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom_range(0, 1)), 1'($urandom)), 1'b0);
        run_inv(5'd4, 10'd1, 32'd0, 1'b1, 1'b1, 6, mk(1'b1, 6'd12, 19'h5, 10'd1, 1'b0), -1);
    endtask

    task automatic test_fill();
        for (int i = 0; i < N + 1; i++)
            tlb_write(0, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), 1'b0), 1'b1);
    endtask

    task automatic test_random();
        logic [18:0] vppns [4];
        vppns[0] = 19'h01234; vppns[1] = 19'h01235; vppns[2] = 19'h7ABCD; vppns[3] = 19'h013FF;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++)
                tlb_write(i, mk(1'($urandom), $urandom_range(0, 1) ? 6'd21 : 6'd12,
                                vppns[$urandom_range(0, 3)],
                                $urandom_range(0, 1) ? 10'h012 : 10'h034, 1'($urandom)),
                          1'($urandom_range(0, 3) == 0));
            run_inv(5'($urandom_range(0, 6)), $urandom_range(0, 1) ? 10'h012 : 10'h034,
                    {vppns[$urandom_range(0, 3)], 13'($urandom)}, 1'($urandom), 1'b0, 0, '0, -1);
        end
    endtask

    task automatic test_reset_mid_walk();
        for (int i = 0; i < N; i++)
            tlb_write(i, mk(1'b1, 6'd12, 19'($urandom), 10'($urandom), 1'($urandom)), 1'b0);
        run_inv(5'd0, 10'd0, 32'd0, 1'b0, 1'b0, 0, '0, 8);
        test_fill();
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        exp_fill   = 0;
        resetn     = 1'b0;
        inv_req    = 1'b0;
        inv_op     = '0;
        inv_asid   = '0;
        inv_va     = '0;
        ws_we      = 1'b0;
        ws_fill    = 1'b0;
        ws_w_index = '0;
        ws_w_entry = '0;
        for (int i = 0; i < N; i++) exp_mem[i] = '0;

        test_reset();
        test_invtlb_all();
        test_global();
        test_va_match();
        test_illegal();
        test_back_to_back();
        test_fill();
        test_random();
        test_reset_mid_walk();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
